// File: rtl/text_engine.sv
// Text-mode instruction executor: runs cursor, write, clear, read-back and
// control-code opcodes against character VRAM through a req/ack port.
module text_engine #(
  parameter int unsigned COLS   = 80,
  parameter int unsigned ROWS   = 30,
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        instruction,
  input  logic [7:0]        arg0,
  input  logic [7:0]        arg1,
  input  logic              instruction_start,
  output logic              instruction_busy,
  output logic              instruction_finished,
  output logic              instruction_error,
  output logic [7:0]        result_0,
  output logic [7:0]        result_1,
  output logic [7:0]        cursor_col,
  output logic [7:0]        cursor_row,
  output logic              vram_req,
  output logic              vram_we,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [15:0]       vram_wdata,
  input  logic [15:0]       vram_rdata,
  input  logic              vram_ack
);

  localparam logic [7:0] OP_WRITE  = 8'h00;
  localparam logic [7:0] OP_POS    = 8'h01;
  localparam logic [7:0] OP_CLEAR  = 8'h02;
  localparam logic [7:0] OP_GET    = 8'h03;
  localparam logic [7:0] OP_CMD    = 8'h04;
  localparam logic [7:0] OP_LIMIT  = 8'h05;

  localparam logic [7:0] CMD_BS    = 8'h08;
  localparam logic [7:0] CMD_LF    = 8'h0A;
  localparam logic [7:0] CMD_CR    = 8'h0D;
  localparam logic [7:0] CHAR_SPC  = 8'h20;

  localparam logic [7:0]        COLS_B    = 8'(COLS);
  localparam logic [7:0]        ROWS_B    = 8'(ROWS);
  localparam logic [7:0]        COL_MAX   = 8'(COLS - 1);
  localparam logic [7:0]        ROW_MAX   = 8'(ROWS - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLS * ROWS - 1);

  // EXEC is the single busy cycle of opcodes that never touch VRAM
  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_WR,
    S_RD,
    S_CLR,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic                busy_q, busy_d;
  logic                fin_q, fin_d;
  logic                err_q, err_d;
  logic [7:0]          res0_q, res0_d;
  logic [7:0]          res1_q, res1_d;
  logic [7:0]          col_q, col_d;
  logic [7:0]          row_q, row_d;
  logic                req_q, req_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [15:0]         wdata_q, wdata_d;
  logic [7:0]          op_q, op_d;
  logic [7:0]          a0_q, a0_d;
  logic [7:0]          a1_q, a1_d;

  function automatic logic in_range(input logic [7:0] col, input logic [7:0] row);
    return (col < COLS_B) && (row < ROWS_B);
  endfunction

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [7:0] col, input logic [7:0] row);
    return ADDR_W'(row) * ADDR_W'(COLS) + ADDR_W'(col);
  endfunction

  // State and registered-output update
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      fin_q   <= 1'b0;
      err_q   <= 1'b0;
      res0_q  <= '0;
      res1_q  <= '0;
      col_q   <= '0;
      row_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      op_q    <= '0;
      a0_q    <= '0;
      a1_q    <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      fin_q   <= fin_d;
      err_q   <= err_d;
      res0_q  <= res0_d;
      res1_q  <= res1_d;
      col_q   <= col_d;
      row_q   <= row_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      op_q    <= op_d;
      a0_q    <= a0_d;
      a1_q    <= a1_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    fin_d   = 1'b0;
    err_d   = err_q;
    res0_d  = res0_q;
    res1_d  = res1_q;
    col_d   = col_q;
    row_d   = row_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    op_d    = op_q;
    a0_d    = a0_q;
    a1_d    = a1_q;

    case (state_q)
      S_IDLE: begin
        if (instruction_start && (instruction < OP_LIMIT)) begin
          busy_d = 1'b1;
          err_d  = 1'b0;
          op_d   = instruction;
          a0_d   = arg0;
          a1_d   = arg1;
          case (instruction)
            OP_WRITE: begin
              state_d = S_WR;
              req_d   = 1'b1;
              we_d    = 1'b1;
              addr_d  = cell_addr(col_q, row_q);
              wdata_d = {arg0, arg1};
            end
            OP_CLEAR: begin
              state_d = S_CLR;
              req_d   = 1'b1;
              we_d    = 1'b1;
              addr_d  = '0;
              wdata_d = {arg0, CHAR_SPC};
            end
            OP_GET: begin
              if (in_range(arg0, arg1)) begin
                state_d = S_RD;
                req_d   = 1'b1;
                we_d    = 1'b0;
                addr_d  = cell_addr(arg0, arg1);
              end else begin
                state_d = S_EXEC;
              end
            end
            default: state_d = S_EXEC;
          endcase
        end
      end

      S_EXEC: begin
        state_d = S_DONE;
        busy_d  = 1'b0;
        fin_d   = 1'b1;
        case (op_q)
          OP_POS: begin
            if (in_range(a0_q, a1_q)) begin
              col_d = a0_q;
              row_d = a1_q;
            end else begin
              err_d = 1'b1;
            end
          end
          OP_CMD: begin
            case (a0_q)
              CMD_BS: begin
                if (col_q != 8'd0) begin
                  col_d = col_q - 8'd1;
                end else if (row_q != 8'd0) begin
                  col_d = COL_MAX;
                  row_d = row_q - 8'd1;
                end
              end
              CMD_LF:  row_d = (row_q == ROW_MAX) ? 8'd0 : row_q + 8'd1;
              CMD_CR:  col_d = 8'd0;
              default: err_d = 1'b1;
            endcase
          end
          // only an out-of-range GET_TEXT_AT lands here
          default: err_d = 1'b1;
        endcase
      end

      S_WR: begin
        if (vram_ack) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          fin_d   = 1'b1;
          req_d   = 1'b0;
          if (col_q == COL_MAX) begin
            col_d = 8'd0;
            row_d = (row_q == ROW_MAX) ? 8'd0 : row_q + 8'd1;
          end else begin
            col_d = col_q + 8'd1;
          end
        end
      end

      S_RD: begin
        if (vram_ack) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          fin_d   = 1'b1;
          req_d   = 1'b0;
          res0_d  = vram_rdata[7:0];
          res1_d  = vram_rdata[15:8];
        end
      end

      S_CLR: begin
        if (vram_ack) begin
          if (addr_q == LAST_ADDR) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            fin_d   = 1'b1;
            req_d   = 1'b0;
            col_d   = 8'd0;
            row_d   = 8'd0;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  assign instruction_busy     = busy_q;
  assign instruction_finished = fin_q;
  assign instruction_error    = err_q;
  assign result_0             = res0_q;
  assign result_1             = res1_q;
  assign cursor_col           = col_q;
  assign cursor_row           = row_q;
  assign vram_req             = req_q;
  assign vram_we              = we_q;
  assign vram_addr            = addr_q;
  assign vram_wdata           = wdata_q;

endmodule

// File: tb/tb_text_engine.sv
// Self-checking bench for text_engine: reset, hand sequences, a vector table
// and randomized opcodes against a cell-index reference model.
module tb_text_engine;

  localparam int NCELL = 80 * 30;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  instruction, arg0, arg1;
  logic        instruction_start;
  logic        instruction_busy, instruction_finished, instruction_error;
  logic [7:0]  result_0, result_1, cursor_col, cursor_row;
  logic        vram_req, vram_we;
  logic [11:0] vram_addr;
  logic [15:0] vram_wdata;
  logic [15:0] vram_rdata;
  logic        vram_ack;

  text_engine dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .instruction          (instruction),
    .arg0                 (arg0),
    .arg1                 (arg1),
    .instruction_start    (instruction_start),
    .instruction_busy     (instruction_busy),
    .instruction_finished (instruction_finished),
    .instruction_error    (instruction_error),
    .result_0             (result_0),
    .result_1             (result_1),
    .cursor_col           (cursor_col),
    .cursor_row           (cursor_row),
    .vram_req             (vram_req),
    .vram_we              (vram_we),
    .vram_addr            (vram_addr),
    .vram_wdata           (vram_wdata),
    .vram_rdata           (vram_rdata),
    .vram_ack             (vram_ack)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // VRAM seen by the DUT, and the contents the model says it should hold
  logic [15:0] vmem    [0:4095];
  logic [15:0] ref_mem [0:4095];

  // responder controls and observations
  int          fix_delay  = 0;
  bit          rand_delay = 0;
  bit          log_en     = 0;
  int          acc_cnt    = 0;
  logic [11:0] last_waddr, last_raddr;
  logic [15:0] last_wdata;
  logic [27:0] wlog[$];

  // reference model state
  int          m_col, m_row;
  logic        m_err;
  logic [7:0]  m_r0, m_r1;
  int          m_waddr, m_raddr;
  logic [15:0] m_wdata;

  typedef struct {
    logic [7:0] op;
    logic [7:0] a0;
    logic [7:0] a1;
    int         col;
    int         row;
    logic       err;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // VRAM slave: acks after a programmable number of waiting cycles
  initial begin : responder
    bit          pend;
    int          wcnt, cur_delay;
    logic [28:0] held;
    vram_ack   = 1'b0;
    vram_rdata = '0;
    pend       = 1'b0;
    wcnt       = 0;
    cur_delay  = 0;
    held       = '0;
    forever begin
      @(negedge clk);
      vram_ack = 1'b0;
      if (!reset_n) begin
        pend = 1'b0;
      end else if (vram_req) begin
        if (!pend) begin
          pend      = 1'b1;
          wcnt      = 0;
          held      = {vram_we, vram_wdata, vram_addr};
          cur_delay = rand_delay ? int'($urandom_range(0, 3)) : fix_delay;
        end else begin
          chk("vram_hold", 32'({vram_we, vram_wdata, vram_addr}), 32'(held));
        end
        if (wcnt >= cur_delay) begin
          vram_ack = 1'b1;
          pend     = 1'b0;
          acc_cnt++;
          if (vram_we) begin
            vmem[vram_addr] = vram_wdata;
            last_waddr      = vram_addr;
            last_wdata      = vram_wdata;
            if (log_en) wlog.push_back({vram_wdata, vram_addr});
          end else begin
            vram_rdata = vmem[vram_addr];
            last_raddr = vram_addr;
          end
        end else begin
          wcnt++;
        end
      end
    end
  end

  // Reference behaviour, using a linear cell index for cursor motion
  task automatic model_op(input logic [7:0] op, input logic [7:0] a0, input logic [7:0] a1,
                          output int exp_acc);
    int p;
    exp_acc = 0;
    if (op >= 8'h05) return;
    m_err = 1'b0;
    case (op)
      8'h00: begin
        p = m_row * 80 + m_col;
        ref_mem[p] = {a0, a1};
        m_waddr = p;
        m_wdata = {a0, a1};
        p = (p + 1) % NCELL;
        m_col = p % 80;
        m_row = p / 80;
        exp_acc = 1;
      end
      8'h01: begin
        if (a0 < 80 && a1 < 30) begin m_col = a0; m_row = a1; end
        else m_err = 1'b1;
      end
      8'h02: begin
        for (int i = 0; i < NCELL; i++) ref_mem[i] = {a0, 8'h20};
        m_col = 0;
        m_row = 0;
        exp_acc = NCELL;
      end
      8'h03: begin
        if (a0 < 80 && a1 < 30) begin
          m_raddr = a1 * 80 + a0;
          m_r0 = ref_mem[m_raddr][7:0];
          m_r1 = ref_mem[m_raddr][15:8];
          exp_acc = 1;
        end else begin
          m_err = 1'b1;
        end
      end
      default: begin
        p = m_row * 80 + m_col;
        if (a0 == 8'h08) begin
          if (p > 0) p--;
          m_col = p % 80;
          m_row = p / 80;
        end else if (a0 == 8'h0A) begin
          m_row = (m_row + 1) % 30;
        end else if (a0 == 8'h0D) begin
          m_col = 0;
        end else begin
          m_err = 1'b1;
        end
      end
    endcase
  endtask

  // One start pulse, then wait (bounded) for the finished pulse
  task automatic do_op(input logic [7:0] op, input logic [7:0] a0, input logic [7:0] a1,
                       output int busy_cyc, output int fin_cnt,
                       output logic busy_at_fin, output logic err_first);
    acc_cnt = 0;
    @(negedge clk);
    instruction       = op;
    arg0              = a0;
    arg1              = a1;
    instruction_start = 1'b1;
    @(negedge clk);
    instruction_start = 1'b0;
    err_first   = instruction_error;
    busy_cyc    = 0;
    fin_cnt     = 0;
    busy_at_fin = 1'b1;
    for (int i = 0; i < 5000 && fin_cnt == 0; i++) begin
      if (instruction_busy) busy_cyc++;
      if (instruction_finished) begin
        fin_cnt     = 1;
        busy_at_fin = instruction_busy;
      end else begin
        @(negedge clk);
      end
    end
    @(negedge clk);
    if (instruction_finished) fin_cnt++;
  endtask

  task automatic exec_check(input logic [7:0] op, input logic [7:0] a0, input logic [7:0] a1,
                            output int busy_cyc);
    int   fc, exp_acc;
    logic baf, ef;
    do_op(op, a0, a1, busy_cyc, fc, baf, ef);
    model_op(op, a0, a1, exp_acc);
    chk("finished_once", 32'(fc), 32'd1);
    chk("busy_at_finish", 32'(baf), 32'd0);
    chk("err_clear_on_start", 32'(ef), 32'd0);
    chk("cursor_col", 32'(cursor_col), 32'(m_col));
    chk("cursor_row", 32'(cursor_row), 32'(m_row));
    chk("error", 32'(instruction_error), 32'(m_err));
    chk("result_0", 32'(result_0), 32'(m_r0));
    chk("result_1", 32'(result_1), 32'(m_r1));
    chk("vram_accesses", 32'(acc_cnt), 32'(exp_acc));
    if (exp_acc == 0) chk("busy_cycles", 32'(busy_cyc), 32'd1);
    if (op == 8'h00) begin
      chk("write_addr", 32'(last_waddr), 32'(m_waddr));
      chk("write_data", 32'(last_wdata), 32'(m_wdata));
    end
    if (op == 8'h03 && exp_acc == 1) chk("read_addr", 32'(last_raddr), 32'(m_raddr));
  endtask

  // Non-text opcode: must produce no busy, no finished, no access, no error change
  task automatic ignore_op(input logic [7:0] op);
    bit   saw_busy, saw_fin;
    logic err0;
    err0     = instruction_error;
    acc_cnt  = 0;
    saw_busy = 1'b0;
    saw_fin  = 1'b0;
    @(negedge clk);
    instruction       = op;
    arg0              = 8'h08;
    arg1              = 8'h00;
    instruction_start = 1'b1;
    @(negedge clk);
    instruction_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (instruction_busy) saw_busy = 1'b1;
      if (instruction_finished) saw_fin = 1'b1;
      @(negedge clk);
    end
    chk("ignored_busy", 32'(saw_busy), 32'd0);
    chk("ignored_finished", 32'(saw_fin), 32'd0);
    chk("ignored_error", 32'(instruction_error), 32'(err0));
    chk("ignored_access", 32'(acc_cnt), 32'd0);
  endtask

  initial begin : main
    int          bc;
    int          nbad;
    int          k;
    logic [7:0]  op, a0, a1;
    logic [7:0]  cmds[5];

    tbl[0]  = '{8'h01, 8'h00, 8'h00,  0,  0, 1'b0};
    tbl[1]  = '{8'h04, 8'h08, 8'h00,  0,  0, 1'b0};
    tbl[2]  = '{8'h04, 8'h0A, 8'h00,  0,  1, 1'b0};
    tbl[3]  = '{8'h04, 8'h08, 8'h00, 79,  0, 1'b0};
    tbl[4]  = '{8'h04, 8'h0D, 8'h00,  0,  0, 1'b0};
    tbl[5]  = '{8'h01, 8'd79, 8'd29, 79, 29, 1'b0};
    tbl[6]  = '{8'h04, 8'h0A, 8'h00, 79,  0, 1'b0};
    tbl[7]  = '{8'h01, 8'd80, 8'd5,  79,  0, 1'b1};
    tbl[8]  = '{8'h01, 8'd3,  8'd30, 79,  0, 1'b1};
    tbl[9]  = '{8'h04, 8'h55, 8'h00, 79,  0, 1'b1};
    tbl[10] = '{8'h01, 8'd3,  8'd4,   3,  4, 1'b0};
    tbl[11] = '{8'h04, 8'h08, 8'h00,  2,  4, 1'b0};

    cmds[0] = 8'h08; cmds[1] = 8'h0A; cmds[2] = 8'h0D; cmds[3] = 8'h08; cmds[4] = 8'h7F;

    for (int i = 0; i < 4096; i++) begin
      vmem[i]    = 16'h0000;
      ref_mem[i] = 16'h0000;
    end
    m_col = 0; m_row = 0; m_err = 1'b0; m_r0 = '0; m_r1 = '0;
    m_waddr = 0; m_raddr = 0; m_wdata = '0;
    last_waddr = '0; last_raddr = '0; last_wdata = '0;
    instruction = '0; arg0 = '0; arg1 = '0; instruction_start = 1'b0;

    // reset values
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(instruction_busy), 32'd0);
    chk("rst_finished", 32'(instruction_finished), 32'd0);
    chk("rst_error", 32'(instruction_error), 32'd0);
    chk("rst_results", 32'({result_1, result_0}), 32'd0);
    chk("rst_cursor", 32'({cursor_row, cursor_col}), 32'd0);
    chk("rst_vram", 32'({vram_req, vram_we, vram_addr, vram_wdata}), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // TEXT_POSITION(5,2)
    exec_check(8'h01, 8'd5, 8'd2, bc);
    chk("pos_busy_one_cycle", 32'(bc), 32'd1);
    chk("pos_col_5", 32'(cursor_col), 32'd5);
    chk("pos_row_2", 32'(cursor_row), 32'd2);

    // cursor/command vector table
    for (int i = 0; i < 12; i++) begin
      exec_check(tbl[i].op, tbl[i].a0, tbl[i].a1, bc);
      chk($sformatf("tbl%0d_col", i), 32'(cursor_col), 32'(tbl[i].col));
      chk($sformatf("tbl%0d_row", i), 32'(cursor_row), 32'(tbl[i].row));
      chk($sformatf("tbl%0d_err", i), 32'(instruction_error), 32'(tbl[i].err));
    end

    // write at the last cell with a slow ack wraps the cursor to (0,0)
    exec_check(8'h01, 8'd79, 8'd29, bc);
    fix_delay = 3;
    exec_check(8'h00, 8'h1F, 8'h41, bc);
    fix_delay = 0;
    chk("wrap_addr_2399", 32'(last_waddr), 32'd2399);
    chk("wrap_wdata", 32'(last_wdata), 32'h1F41);
    chk("wrap_busy_cycles", 32'(bc), 32'd4);
    chk("wrap_cursor", 32'({cursor_row, cursor_col}), 32'd0);

    // full clear with ack every cycle
    wlog.delete();
    log_en = 1'b1;
    exec_check(8'h02, 8'h07, 8'h00, bc);
    log_en = 1'b0;
    chk("clear_busy_cycles", 32'(bc), 32'(NCELL));
    chk("clear_log_size", 32'(wlog.size()), 32'(NCELL));
    nbad = 0;
    for (int i = 0; i < wlog.size(); i++)
      if (wlog[i] !== {16'h0720, 12'(i)}) nbad++;
    chk("clear_order_data", 32'(nbad), 32'd0);

    // read-back of a known cell, then an out-of-range read
    vmem[90]    = 16'h4E58;
    ref_mem[90] = 16'h4E58;
    exec_check(8'h03, 8'd10, 8'd1, bc);
    chk("get_addr_90", 32'(last_raddr), 32'd90);
    chk("get_r0", 32'(result_0), 32'h58);
    chk("get_r1", 32'(result_1), 32'h4E);
    exec_check(8'h03, 8'd80, 8'd0, bc);
    chk("get_oob_err", 32'(instruction_error), 32'd1);
    chk("get_oob_r0", 32'(result_0), 32'h58);

    // backspace at home, bad command, error cleared by next start
    exec_check(8'h01, 8'd0, 8'd0, bc);
    exec_check(8'h04, 8'h08, 8'h00, bc);
    chk("bs_home_cursor", 32'({cursor_row, cursor_col}), 32'd0);
    chk("bs_home_err", 32'(instruction_error), 32'd0);
    exec_check(8'h04, 8'h55, 8'h00, bc);
    chk("bad_cmd_err", 32'(instruction_error), 32'd1);
    ignore_op(8'h07);
    exec_check(8'h01, 8'd1, 8'd1, bc);
    chk("err_cleared", 32'(instruction_error), 32'd0);

    // randomized opcodes with random ack latency
    rand_delay = 1'b1;
    for (int n = 0; n < 80; n++) begin
      k  = int'($urandom_range(0, 9));
      a0 = 8'($urandom);
      a1 = 8'($urandom);
      if (k <= 2) begin
        op = 8'h00;
      end else if (k <= 4) begin
        op = 8'h01; a0 = 8'($urandom_range(0, 85)); a1 = 8'($urandom_range(0, 33));
      end else if (k <= 6) begin
        op = 8'h03; a0 = 8'($urandom_range(0, 85)); a1 = 8'($urandom_range(0, 33));
      end else if (k <= 8) begin
        op = 8'h04; a0 = cmds[$urandom_range(0, 4)];
      end else begin
        op = 8'($urandom_range(5, 255));
      end
      if (op >= 8'h05) ignore_op(op);
      else exec_check(op, a0, a1, bc);
    end
    rand_delay = 1'b0;

    // async reset in the middle of a clear
    @(negedge clk);
    instruction = 8'h02; arg0 = 8'h01; arg1 = 8'h00; instruction_start = 1'b1;
    @(negedge clk);
    instruction_start = 1'b0;
    repeat (100) @(negedge clk);
    chk("midclr_req_before", 32'(vram_req), 32'd1);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("midclr_req_drop", 32'(vram_req), 32'd0);
    chk("midclr_busy_drop", 32'(instruction_busy), 32'd0);
    chk("midclr_no_finish", 32'(instruction_finished), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    chk("midclr_cursor", 32'({cursor_row, cursor_col}), 32'd0);
    ignore_op(8'h10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // absolute time bound on the whole run
  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1);
  end

endmodule
